// File: rtl/led_disp_pkg.sv
// Shared definitions for the LED scan controller.
//   NUM_COLS / SEG_W : display geometry (columns x segment lines)
//   COL_W            : column index width
//   scan_state_t     : scan FSM states
//   BLANK_PAT        : all segments off (active-low)
package led_disp_pkg;

  localparam int NUM_COLS = 16;
  localparam int SEG_W    = 16;
  localparam int COL_W    = $clog2(NUM_COLS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  localparam logic [SEG_W-1:0] BLANK_PAT = '1;

endpackage

// File: rtl/led_scan_ctrl_if.sv
// Host-side write/swap port of the LED scan controller.
//   wr_valid/wr_ready/wr_addr/wr_data : pattern write into the back buffer
//   swap_req/swap_ack                 : front/back swap request and completion
//
// Handshake: a write transfers on a rising clock edge where wr_valid and
// wr_ready are both high; wr_addr/wr_data must be stable while wr_valid is
// high. wr_valid may be held across cycles where wr_ready is low (no
// transfer happens). swap_req is a one-cycle pulse, ignored while a swap is
// already pending; swap_ack is a one-cycle pulse when the swap takes effect.
interface led_scan_ctrl_if;
  import led_disp_pkg::*;

  logic             wr_valid;
  logic             wr_ready;
  logic [COL_W-1:0] wr_addr;
  logic [SEG_W-1:0] wr_data;
  logic             swap_req;
  logic             swap_ack;

  modport master (
    output wr_valid, wr_addr, wr_data, swap_req,
    input  wr_ready, swap_ack
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, swap_req,
    output wr_ready, swap_ack
  );

endinterface

// File: rtl/led_frame_buf.sv
// Double-buffered NUM_COLS x SEG_W pattern store.
//   clk, rst_n  : clock, async active-low reset (both banks to BLANK_PAT)
//   wr_en_i     : write wr_data_i into back bank at wr_addr_i
//   rd_addr_i   : combinational read address into the front bank
//   rd_data_o   : front bank contents at rd_addr_i
//   swap_i      : exchange front and back banks
module led_frame_buf
  import led_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [COL_W-1:0] wr_addr_i,
  input  logic [SEG_W-1:0] wr_data_i,
  input  logic [COL_W-1:0] rd_addr_i,
  input  logic             swap_i,
  output logic [SEG_W-1:0] rd_data_o
);

  logic [SEG_W-1:0] bank_q [2][NUM_COLS];
  logic             front_sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          bank_q[b][c] <= BLANK_PAT;
        end
      end
      front_sel_q <= 1'b0;
    end else begin
      // The back bank is always the one not selected for display.
      if (wr_en_i) begin
        bank_q[~front_sel_q][wr_addr_i] <= wr_data_i;
      end
      if (swap_i) begin
        front_sel_q <= ~front_sel_q;
      end
    end
  end

  assign rd_data_o = bank_q[front_sel_q][rd_addr_i];

endmodule

// File: rtl/led_scan_ctrl.sv
// Time-multiplexed scan controller for a NUM_COLS x SEG_W LED display.
//   clk, rst_n   : clock, async active-low reset
//   enable       : scan enable; low forces IDLE with all lines off
//   brightness   : PWM level, on-time = (brightness+1)/16 of the dwell
//   host         : write/swap port (slave side of led_scan_ctrl_if)
//   frame_start  : one-cycle pulse on entering BLANK for column 0
//   led_col_n    : one-hot-low column select (registered)
//   led_seg_n    : active-low segment lines (registered)
//   dbg_state_o  : current scan FSM state
module led_scan_ctrl
  import led_disp_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 4096,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [3:0]          brightness,
  led_scan_ctrl_if.slave      host,
  output logic                frame_start,
  output logic [NUM_COLS-1:0] led_col_n,
  output logic [SEG_W-1:0]    led_seg_n,
  output scan_state_t         dbg_state_o
);

  localparam int unsigned MAXC    = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int          CNT_W   = $clog2(MAXC);
  localparam int          ON_W    = CNT_W + 1;
  localparam int unsigned ON_STEP = DWELL_CYCLES / 16;
  localparam logic [NUM_COLS-1:0] COL_ONE = NUM_COLS'(1);

  scan_state_t         state_q;
  logic [COL_W-1:0]    col_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ON_W-1:0]     on_q;
  logic                frame_start_q;
  logic [NUM_COLS-1:0] col_n_q;
  logic [SEG_W-1:0]    seg_n_q;
  logic                swap_pending_q;
  logic                wr_ready_q;
  logic                swap_ack_q;

  logic                blank_end;
  logic                dwell_end;
  logic                last_col;
  logic                frame_entry;
  logic                swap_exec;
  logic                wr_fire;
  logic                swap_set;
  logic                drive_on_next;
  logic [ON_W-1:0]     on_d;
  logic [SEG_W-1:0]    front_data;

  always_comb begin
    blank_end     = (state_q == BLANK) && (cnt_q == CNT_W'(BLANK_CYCLES - 1));
    dwell_end     = (state_q == DRIVE) && (cnt_q == CNT_W'(DWELL_CYCLES - 1));
    last_col      = (col_q == COL_W'(NUM_COLS - 1));
    // Entering BLANK with col 0: either leaving IDLE or wrapping past the last column.
    frame_entry   = enable && ((state_q == IDLE) || (dwell_end && last_col));
    swap_exec     = swap_pending_q && (frame_entry || (state_q == IDLE));
    wr_fire       = host.wr_valid && wr_ready_q;
    swap_set      = host.swap_req && !swap_pending_q;
    // DWELL_CYCLES is a multiple of 16, so this equals ((b+1)*DWELL)>>4 exactly.
    on_d          = ON_W'(ON_STEP) * ON_W'({1'b0, brightness} + 5'd1);
    // Outputs are registered, so decide on the dwell count the next cycle will have.
    drive_on_next = ({1'b0, cnt_q} + ON_W'(1)) < on_q;
  end

  led_frame_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_fire),
    .wr_addr_i (host.wr_addr),
    .wr_data_i (host.wr_data),
    .rd_addr_i (col_q),
    .swap_i    (swap_exec),
    .rd_data_o (front_data)
  );

  // Scan FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      col_q         <= '0;
      cnt_q         <= '0;
      on_q          <= '0;
      frame_start_q <= 1'b0;
      col_n_q       <= '1;
      seg_n_q       <= BLANK_PAT;
    end else begin
      frame_start_q <= 1'b0;
      col_n_q       <= '1;
      seg_n_q       <= BLANK_PAT;
      if (!enable) begin
        state_q <= IDLE;
        col_q   <= '0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q       <= BLANK;
            col_q         <= '0;
            cnt_q         <= '0;
            frame_start_q <= 1'b1;
          end
          BLANK: begin
            if (blank_end) begin
              state_q <= DRIVE;
              cnt_q   <= '0;
              on_q    <= on_d;
              // on_d is never below DWELL_CYCLES/16, so the first dwell cycle is always lit.
              col_n_q <= ~(COL_ONE << col_q);
              seg_n_q <= front_data;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          DRIVE: begin
            if (dwell_end) begin
              state_q       <= BLANK;
              cnt_q         <= '0;
              col_q         <= col_q + 1'b1;
              frame_start_q <= last_col;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              if (drive_on_next) begin
                col_n_q <= ~(COL_ONE << col_q);
                seg_n_q <= front_data;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Write/swap handshake. wr_ready stays low through the swap edge and
  // recovers on the clock after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_pending_q <= 1'b0;
      wr_ready_q     <= 1'b1;
      swap_ack_q     <= 1'b0;
    end else begin
      swap_ack_q <= swap_exec;
      if (swap_exec) begin
        swap_pending_q <= 1'b0;
      end else if (swap_set) begin
        swap_pending_q <= 1'b1;
      end
      wr_ready_q <= !(swap_pending_q || swap_set);
    end
  end

  assign host.wr_ready = wr_ready_q;
  assign host.swap_ack = swap_ack_q;
  assign frame_start   = frame_start_q;
  assign led_col_n     = col_n_q;
  assign led_seg_n     = seg_n_q;
  assign dbg_state_o   = state_q;

endmodule
